bram_scan_ctrl: RTL and testbench

BRAM_SCAN_CTRL -- requirements
Module: bram_scan_ctrl

---
 rtl/bram_scan_ctrl.sv | 137 +++++++++++++
 tb/tb_bram_scan_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_scan_ctrl.sv
// Scan controller for a serial load/capture harness around a BRAM region of interest.
// Shifts a latched vector in twice (strobing after each pass), then shifts the ROI response back out.
module bram_scan_ctrl #(
    parameter int DIN_N  = 256,
    parameter int DOUT_N = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DIN_N-1:0]  load_vec,
    output logic              busy,
    output logic              done,
    output logic              cap_valid,
    output logic [DOUT_N-1:0] cap_vec,
    output logic              di,
    output logic              stb,
    input  logic              do_in
);

    localparam int MAX_N = (DIN_N > DOUT_N) ? DIN_N : DOUT_N;
    localparam int CW    = $clog2(MAX_N) + 1;

    localparam logic [CW-1:0] DIN_LAST  = CW'(DIN_N - 1);
    localparam logic [CW-1:0] DOUT_LAST = CW'(DOUT_N - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT1,
        STB1,
        SHIFT2,
        STB2,
        SHIFT_OUT,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DIN_N-1:0]  vec_q, vec_d;
    logic [DOUT_N-1:0] cap_q, cap_d;
    logic              cap_valid_q, cap_valid_d;
    logic              di_q, di_d;
    logic              stb_q, stb_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        vec_d       = vec_q;
        cap_d       = cap_q;
        cap_valid_d = cap_valid_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    vec_d       = load_vec;
                    cap_valid_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = SHIFT1;
                end
            end
            SHIFT1, SHIFT2: begin
                // Rotating (not shifting) leaves the vector intact after a full pass for the re-shift.
                vec_d = {vec_q[DIN_N-2:0], vec_q[DIN_N-1]};
                if (cnt_q == DIN_LAST) begin
                    cnt_d   = '0;
                    state_d = (state_q == SHIFT1) ? STB1 : STB2;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STB1: begin
                cnt_d   = '0;
                state_d = SHIFT2;
            end
            STB2: begin
                cnt_d   = '0;
                state_d = SHIFT_OUT;
            end
            SHIFT_OUT: begin
                cap_d = {cap_q[DOUT_N-2:0], do_in};
                if (cnt_q == DOUT_LAST) begin
                    cnt_d       = '0;
                    cap_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // Outputs are registered, so they are derived from the upcoming state.
        di_d   = ((state_d == SHIFT1) || (state_d == SHIFT2)) ? vec_d[DIN_N-1] : 1'b0;
        stb_d  = (state_d == STB1) || (state_d == STB2);
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            vec_q       <= '0;
            cap_q       <= '0;
            cap_valid_q <= 1'b0;
            di_q        <= 1'b0;
            stb_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            vec_q       <= vec_d;
            cap_q       <= cap_d;
            cap_valid_q <= cap_valid_d;
            di_q        <= di_d;
            stb_q       <= stb_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign cap_valid = cap_valid_q;
    assign cap_vec   = cap_q;
    assign di        = di_q;
    assign stb       = stb_q;

endmodule

// File: tb/tb_bram_scan_ctrl.sv
// Bench for bram_scan_ctrl: 8/8 and 256/256 instances, each driving a behavioural harness + ROI model.
module tb_bram_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int checks = 0;
    int errors = 0;

    // 8/8 instance
    logic       start8;
    logic [7:0] load8;
    logic       busy8, done8, capv8, di8, stb8, do8;
    logic [7:0] cap8;

    // 256/256 instance
    logic         start_w;
    logic [255:0] load_w;
    logic         busy_w, done_w, capv_w, di_w, stb_w, do_w;
    logic [255:0] cap_w;

    logic [7:0]   exp_q8[$];
    logic [255:0] exp_qw[$];
    logic         inv_mode = 1'b0;

    bram_scan_ctrl #(.DIN_N(8), .DOUT_N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .load_vec(load8),
        .busy(busy8), .done(done8), .cap_valid(capv8), .cap_vec(cap8),
        .di(di8), .stb(stb8), .do_in(do8)
    );

    bram_scan_ctrl #(.DIN_N(256), .DOUT_N(256)) dutw (
        .clk(clk), .rst_n(rst_n), .start(start_w), .load_vec(load_w),
        .busy(busy_w), .done(done_w), .cap_valid(capv_w), .cap_vec(cap_w),
        .di(di_w), .stb(stb_w), .do_in(do_w)
    );

    // Harness model: chains shift each edge, strobe loads ROI inputs and the output chain.
    logic [7:0] h_in = '0, h_roi_in = '0, h_roi_reg = '0, h_out = '0;
    logic [7:0] h_roi_out;
    assign h_roi_out = inv_mode ? h_roi_reg : h_roi_in;
    always @(posedge clk) begin
        h_roi_reg <= ~h_roi_in;
        if (stb8) begin
            h_roi_in <= h_in;
            h_out    <= h_roi_out;
        end else begin
            h_in  <= {h_in[6:0], di8};
            h_out <= {h_out[6:0], 1'b0};
        end
    end
    assign do8 = h_out[7];

    logic [255:0] hw_in = '0, hw_roi_in = '0, hw_out = '0;
    always @(posedge clk) begin
        if (stb_w) begin
            hw_roi_in <= hw_in;
            hw_out    <= hw_roi_in;
        end else begin
            hw_in  <= {hw_in[254:0], di_w};
            hw_out <= {hw_out[254:0], 1'b0};
        end
    end
    assign do_w = hw_out[255];

    task automatic test_reset();
        rst_n = 1'b0; start8 = 1'b0; start_w = 1'b0; load8 = '0; load_w = '0;
        #1;
        checks++;
        if ({busy8, done8, capv8, di8, stb8} !== 5'b0 || cap8 !== 8'h00) begin
            errors++;
            $display("FAIL reset8: outs=%b cap=%h, want outs=00000 cap=00", {busy8, done8, capv8, di8, stb8}, cap8);
        end
        checks++;
        if ({busy_w, done_w, capv_w, di_w, stb_w} !== 5'b0 || cap_w !== '0) begin
            errors++;
            $display("FAIL reset256: outs=%b cap_nonzero=%b, want all zero", {busy_w, done_w, capv_w, di_w, stb_w}, |cap_w);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        $display("test_reset: done");
    endtask

    task automatic run_scan8(input logic [7:0] v, input logic [7:0] expv, input string name);
        logic [7:0] tr1, tr2;
        logic [7:0] got;
        int done_at, nstb, stb_a, stb_b;
        logic di_in_stb;
        tr1 = '0; tr2 = '0; done_at = 0; nstb = 0; stb_a = 0; stb_b = 0; di_in_stb = 1'b0;
        @(negedge clk);
        load8 = v; start8 = 1'b1;
        exp_q8.push_back(expv);
        @(posedge clk);
        #1 start8 = 1'b0; load8 = ~v;
        for (int c = 1; c <= 40 && done_at == 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checks++;
                if (busy8 !== 1'b1 || capv8 !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_start: busy=%b cap_valid=%b, want busy=1 cap_valid=0", name, busy8, capv8);
                end
            end
            if (c >= 1 && c <= 8) tr1[8-c] = di8;
            if (c >= 10 && c <= 17) tr2[17-c] = di8;
            if (stb8 === 1'b1) begin
                nstb++;
                if (nstb == 1) stb_a = c; else stb_b = c;
                di_in_stb |= di8;
            end
            if (done8 === 1'b1) begin
                done_at = c;
                got = (exp_q8.size() > 0) ? exp_q8.pop_front() : 8'hxx;
                checks++;
                if (cap8 !== got || capv8 !== 1'b1 || busy8 !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_cap: cap_vec=%h cap_valid=%b busy=%b, want cap_vec=%h cap_valid=1 busy=1", name, cap8, capv8, busy8, got);
                end
            end
        end
        checks++;
        if (done_at != 27) begin
            errors++;
            $display("FAIL %s_latency: done at cycle %0d, want 27", name, done_at);
        end
        checks++;
        if (nstb != 2 || stb_a != 9 || stb_b != 18 || di_in_stb !== 1'b0) begin
            errors++;
            $display("FAIL %s_stb: count=%0d at %0d,%0d di_in_stb=%b, want count=2 at 9,18 di_in_stb=0", name, nstb, stb_a, stb_b, di_in_stb);
        end
        checks++;
        if (tr1 !== v || tr2 !== v) begin
            errors++;
            $display("FAIL %s_di: pass1=%b pass2=%b, want %b both", name, tr1, tr2, v);
        end
        $display("%s: vec=%h done_at=%0d cap_vec=%h", name, v, done_at, cap8);
    endtask

    task automatic test_loopback();
        inv_mode = 1'b0;
        run_scan8(8'hA5, 8'hA5, "loopback_a5");
        run_scan8(8'h81, 8'h81, "loopback_81");
    endtask

    task automatic test_invert();
        inv_mode = 1'b1;
        run_scan8(8'h0F, 8'hF0, "invert_0f");
        run_scan8(8'h6C, 8'h93, "invert_6c");
        inv_mode = 1'b0;
    endtask

    task automatic test_back_to_back();
        int dones[$];
        int nstb;
        logic [7:0] got;
        nstb = 0;
        @(negedge clk);
        load8 = 8'h5B; start8 = 1'b1;
        for (int c = 1; c <= 110; c++) begin
            @(negedge clk);
            if (c == 60) start8 = 1'b0;
            if (c == 1 || c == 29 || c == 57) exp_q8.push_back(8'h5B);
            if (stb8 === 1'b1) nstb++;
            if (done8 === 1'b1) begin
                dones.push_back(c);
                got = (exp_q8.size() > 0) ? exp_q8.pop_front() : 8'hxx;
                checks++;
                if (cap8 !== got) begin
                    errors++;
                    $display("FAIL b2b_cap: cap_vec=%h, want %h at cycle %0d", cap8, got, c);
                end
            end
        end
        checks++;
        if (dones.size() != 3 || nstb != 6) begin
            errors++;
            $display("FAIL b2b_count: dones=%0d stb=%0d, want dones=3 stb=6", dones.size(), nstb);
        end else begin
            checks++;
            if (dones[0] != 27 || dones[1] != 55 || dones[2] != 83) begin
                errors++;
                $display("FAIL b2b_spacing: dones at %0d,%0d,%0d, want 27,55,83", dones[0], dones[1], dones[2]);
            end
        end
        $display("test_back_to_back: dones=%0d stb=%0d", dones.size(), nstb);
    endtask

    task automatic test_reset_midscan();
        int nstb;
        nstb = 0;
        @(negedge clk);
        load8 = 8'hC3; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        for (int c = 1; c <= 12; c++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy8, done8, capv8, di8, stb8} !== 5'b0 || cap8 !== 8'h00) begin
            errors++;
            $display("FAIL midscan_reset: outs=%b cap=%h, want outs=00000 cap=00", {busy8, done8, capv8, di8, stb8}, cap8);
        end
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (c == 4) rst_n = 1'b1;
            if (stb8 === 1'b1 || busy8 === 1'b1) nstb++;
        end
        checks++;
        if (nstb != 0) begin
            errors++;
            $display("FAIL midscan_quiet: %0d cycles with stb/busy, want 0", nstb);
        end
        $display("test_reset_midscan: aborted in SHIFT2, quiet cycles checked");
        run_scan8(8'h3C, 8'h3C, "after_reset_3c");
    endtask

    task automatic test_default256();
        logic [255:0] v, got;
        int done_at;
        done_at = 0;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
        @(negedge clk);
        load_w = v; start_w = 1'b1;
        exp_qw.push_back(v);
        @(posedge clk);
        #1 start_w = 1'b0; load_w = '0;
        for (int c = 1; c <= 800 && done_at == 0; c++) begin
            @(negedge clk);
            if (done_w === 1'b1) begin
                done_at = c;
                got = (exp_qw.size() > 0) ? exp_qw.pop_front() : 'x;
                checks++;
                if (cap_w !== got || capv_w !== 1'b1) begin
                    errors++;
                    $display("FAIL w256_cap: cap_vec=%h cap_valid=%b, want %h cap_valid=1", cap_w, capv_w, got);
                end
            end
        end
        checks++;
        if (done_at != 771) begin
            errors++;
            $display("FAIL w256_latency: done at cycle %0d, want 771", done_at);
        end
        $display("test_default256: done_at=%0d cap_low=%h", done_at, cap_w[31:0]);
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_invert();
        test_back_to_back();
        test_reset_midscan();
        test_default256();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
